apb_master_bridge: RTL

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge_if.sv | 45 ++++
 rtl/apb_master_bridge.sv | 119 +++++++++++
 2 files changed

// File: rtl/apb_master_bridge_if.sv
// Bundle of CPU request/response and APB bus signals for apb_master_bridge.
// The master modport is the bridge side; the slave modport is the CPU plus APB responder.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_strb;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_strb,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_strb,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding CPU-request to APB master bridge (IDLE/SETUP/ACCESS/RESP).
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT wait cycles.
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    apb_master_bridge_if.master bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t            state_reg;
    logic              req_ready_reg;
    logic              psel_reg;
    logic              penable_reg;
    logic              pwrite_reg;
    logic [ADDR_W-1:0] paddr_reg;
    logic [DATA_W-1:0] pwdata_reg;
    logic [STRB_W-1:0] pstrb_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_err_reg;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [CNT_W-1:0] tmo_cnt_reg;
    logic             tmo_hit;
    // The wait cycle that would bring the count to TIMEOUT ends the access.
    assign tmo_hit = !bus.pready && (tmo_cnt_reg == CNT_W'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b1;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            pstrb_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_reg   <= '0;
`endif
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        state_reg     <= SETUP;
                        req_ready_reg <= 1'b0;
                        psel_reg      <= 1'b1;
                        pwrite_reg    <= bus.req_write;
                        paddr_reg     <= bus.req_addr;
                        pwdata_reg    <= bus.req_wdata;
                        pstrb_reg     <= bus.req_write ? bus.req_strb : '0;
                    end
                end
                SETUP: begin
                    state_reg   <= ACCESS;
                    penable_reg <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    tmo_cnt_reg <= '0;
`endif
                end
                ACCESS: begin
                    if (bus.pready) begin
                        state_reg     <= RESP;
                        psel_reg      <= 1'b0;
                        penable_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_rdata_reg <= pwrite_reg ? '0 : bus.prdata;
                        rsp_err_reg   <= bus.pslverr;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state_reg     <= RESP;
                        psel_reg      <= 1'b0;
                        penable_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_rdata_reg <= '0;
                        rsp_err_reg   <= 1'b1;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                    psel_reg      <= 1'b0;
                    penable_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.psel      = psel_reg;
    assign bus.penable   = penable_reg;
    assign bus.pwrite    = pwrite_reg;
    assign bus.paddr     = paddr_reg;
    assign bus.pwdata    = pwdata_reg;
    assign bus.pstrb     = pstrb_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;
endmodule
